// File: rtl/if_stage.sv
// Instruction fetch stage: drives a request/ack instruction memory and presents
// {pc, instruction} to IF_ID, handling stalls, redirects and stale responses.
module if_stage #(
  parameter int unsigned                WORD_BITWIDTH = 32,
  parameter logic [WORD_BITWIDTH-1:0]   RESET_PC      = {WORD_BITWIDTH{1'b0}},
  parameter logic [WORD_BITWIDTH-1:0]   NOP_INSTR     = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hz_write,
  input  logic                     br_taken,
  input  logic [WORD_BITWIDTH-1:0] br_target,
  output logic                     imem_req,
  output logic [WORD_BITWIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [WORD_BITWIDTH-1:0] imem_rdata,
  output logic [WORD_BITWIDTH-1:0] pc,
  output logic [WORD_BITWIDTH-1:0] instruction
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                   r_state,     w_state_nxt;
  logic [WORD_BITWIDTH-1:0] r_fetch_pc,  w_fetch_pc_nxt;
  logic [WORD_BITWIDTH-1:0] r_imem_addr, w_imem_addr_nxt;
  logic [WORD_BITWIDTH-1:0] r_buf_instr, w_buf_instr_nxt;
  logic [WORD_BITWIDTH-1:0] r_pc,        w_pc_nxt;
  logic [WORD_BITWIDTH-1:0] r_instr,     w_instr_nxt;
  logic                     r_imem_req,  w_imem_req_nxt;

  logic [WORD_BITWIDTH-1:0] w_pc_inc;
  logic [WORD_BITWIDTH-1:0] w_target;

  // Increment wraps naturally at the word width; redirects are word aligned.
  assign w_pc_inc = r_fetch_pc + {{(WORD_BITWIDTH-3){1'b0}}, 3'd4};
  assign w_target = {br_target[WORD_BITWIDTH-1:2], 2'b00};

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_imem_addr_nxt = r_imem_addr;
    w_buf_instr_nxt = r_buf_instr;
    w_pc_nxt        = r_pc;
    w_instr_nxt     = r_instr;
    case (r_state)
      IDLE: begin
        w_state_nxt     = FETCH;
        w_imem_addr_nxt = r_fetch_pc;
      end
      FETCH: begin
        if (br_taken) begin
          w_fetch_pc_nxt = w_target;
          w_instr_nxt    = NOP_INSTR;
          w_pc_nxt       = w_target;
          if (imem_ack) begin
            w_imem_addr_nxt = w_target;
          end else begin
            // Outstanding request must still be drained before re-targeting.
            w_state_nxt = FLUSH;
          end
        end else if (imem_ack) begin
          if (!hz_write) begin
            w_pc_nxt        = r_fetch_pc;
            w_instr_nxt     = imem_rdata;
            w_fetch_pc_nxt  = w_pc_inc;
            w_imem_addr_nxt = w_pc_inc;
          end else begin
            w_buf_instr_nxt = imem_rdata;
            w_state_nxt     = HOLD;
          end
        end else begin
          if (!hz_write) begin
            w_instr_nxt = NOP_INSTR;
            w_pc_nxt    = r_fetch_pc;
          end else begin
            w_instr_nxt = r_instr;
          end
        end
      end
      HOLD: begin
        if (br_taken) begin
          w_fetch_pc_nxt  = w_target;
          w_imem_addr_nxt = w_target;
          w_instr_nxt     = NOP_INSTR;
          w_pc_nxt        = w_target;
          w_state_nxt     = FETCH;
        end else if (!hz_write) begin
          w_pc_nxt        = r_fetch_pc;
          w_instr_nxt     = r_buf_instr;
          w_fetch_pc_nxt  = w_pc_inc;
          w_imem_addr_nxt = w_pc_inc;
          w_state_nxt     = FETCH;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      FLUSH: begin
        if (!hz_write) begin
          w_instr_nxt = NOP_INSTR;
          w_pc_nxt    = r_fetch_pc;
        end else begin
          w_instr_nxt = r_instr;
        end
        if (imem_ack) begin
          // Stale response is dropped; a same-cycle redirect wins the new address.
          w_fetch_pc_nxt  = br_taken ? w_target : r_fetch_pc;
          w_imem_addr_nxt = br_taken ? w_target : r_fetch_pc;
          w_state_nxt     = FETCH;
        end else if (br_taken) begin
          w_fetch_pc_nxt = w_target;
        end else begin
          w_state_nxt = FLUSH;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_imem_req_nxt = (w_state_nxt == FETCH) || (w_state_nxt == FLUSH);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_imem_addr <= RESET_PC;
      r_buf_instr <= {WORD_BITWIDTH{1'b0}};
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_imem_req  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_buf_instr <= w_buf_instr_nxt;
      r_pc        <= w_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_imem_req  <= w_imem_req_nxt;
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign pc          = r_pc;
  assign instruction = r_instr;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: streaming, stall/hold, flush,
// wait-state bubbles, PC wrap, asynchronous reset and redirect out of HOLD.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        hz_write;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instruction;

  int n_checks = 0;
  int n_errors = 0;

  if_stage #(
    .WORD_BITWIDTH(32),
    .RESET_PC     (32'h00000000),
    .NOP_INSTR    (32'h00000013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hz_write   (hz_write),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .instruction(instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hz_write = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    n_checks++; if (instruction !== NOP) begin n_errors++; $display("FAIL reset_instr got %h exp %h", instruction, NOP); end
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, 32'h0); end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL stream_req got %b exp 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL stream_addr0 got %h exp 0", imem_addr); end
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; imem_rdata = mem_word(32'(i * 4));
      tick();
      n_checks++; if (pc !== 32'(i * 4)) begin n_errors++; $display("FAIL stream_pc got %h exp %h", pc, 32'(i * 4)); end
      n_checks++; if (instruction !== mem_word(32'(i * 4))) begin n_errors++; $display("FAIL stream_instr got %h exp %h", instruction, mem_word(32'(i * 4))); end
      n_checks++; if (imem_addr !== 32'(i * 4 + 4)) begin n_errors++; $display("FAIL stream_addr got %h exp %h", imem_addr, 32'(i * 4 + 4)); end
    end
  endtask

  task automatic test_stall_hold();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h10); hz_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc !== 32'hC) begin n_errors++; $display("FAIL hold_pc got %h exp %h", pc, 32'hC); end
      n_checks++; if (instruction !== mem_word(32'hC)) begin n_errors++; $display("FAIL hold_instr got %h exp %h", instruction, mem_word(32'hC)); end
      n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL hold_req got %b exp 0", imem_req); end
      // Spurious ack while no request is outstanding must be ignored.
      imem_ack = (i == 0) ? 1'b1 : 1'b0; imem_rdata = 32'hDEADBEEF;
    end
    hz_write = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    tick();
    n_checks++; if (pc !== 32'h10) begin n_errors++; $display("FAIL release_pc got %h exp %h", pc, 32'h10); end
    n_checks++; if (instruction !== mem_word(32'h10)) begin n_errors++; $display("FAIL release_instr got %h exp %h", instruction, mem_word(32'h10)); end
    n_checks++; if (imem_addr !== 32'h14) begin n_errors++; $display("FAIL release_addr got %h exp %h", imem_addr, 32'h14); end
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL release_req got %b exp 1", imem_req); end
  endtask

  task automatic test_flush();
    br_taken = 1'b1; br_target = 32'h40; imem_ack = 1'b1; imem_rdata = mem_word(32'h14);
    tick();
    n_checks++; if (imem_addr !== 32'h40) begin n_errors++; $display("FAIL redir_addr got %h exp %h", imem_addr, 32'h40); end
    n_checks++; if (instruction !== NOP) begin n_errors++; $display("FAIL redir_instr got %h exp %h", instruction, NOP); end
    n_checks++; if (pc !== 32'h40) begin n_errors++; $display("FAIL redir_pc got %h exp %h", pc, 32'h40); end
    br_target = 32'h203; imem_ack = 1'b0;
    tick();
    n_checks++; if (imem_addr !== 32'h40) begin n_errors++; $display("FAIL flush_addr got %h exp %h", imem_addr, 32'h40); end
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL flush_req got %b exp 1", imem_req); end
    n_checks++; if (pc !== 32'h200) begin n_errors++; $display("FAIL flush_pc got %h exp %h", pc, 32'h200); end
    br_taken = 1'b0;
    tick();
    n_checks++; if (imem_addr !== 32'h40) begin n_errors++; $display("FAIL flush_wait_addr got %h exp %h", imem_addr, 32'h40); end
    n_checks++; if (instruction !== NOP) begin n_errors++; $display("FAIL flush_wait_instr got %h exp %h", instruction, NOP); end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h40);
    tick();
    n_checks++; if (instruction !== NOP) begin n_errors++; $display("FAIL flush_stale_instr got %h exp %h", instruction, NOP); end
    n_checks++; if (imem_addr !== 32'h200) begin n_errors++; $display("FAIL flush_next_addr got %h exp %h", imem_addr, 32'h200); end
    imem_rdata = mem_word(32'h200);
    tick();
    n_checks++; if (pc !== 32'h200) begin n_errors++; $display("FAIL target_pc got %h exp %h", pc, 32'h200); end
    n_checks++; if (instruction !== mem_word(32'h200)) begin n_errors++; $display("FAIL target_instr got %h exp %h", instruction, mem_word(32'h200)); end
    n_checks++; if (imem_addr !== 32'h204) begin n_errors++; $display("FAIL target_addr got %h exp %h", imem_addr, 32'h204); end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 2; i++) begin
      imem_ack = 1'b0;
      tick();
      n_checks++; if (instruction !== NOP) begin n_errors++; $display("FAIL bubble_instr got %h exp %h", instruction, NOP); end
      n_checks++; if (pc !== 32'(32'h204 + i * 4)) begin n_errors++; $display("FAIL bubble_pc got %h exp %h", pc, 32'(32'h204 + i * 4)); end
      imem_ack = 1'b1; imem_rdata = mem_word(32'(32'h204 + i * 4));
      tick();
      n_checks++; if (instruction !== mem_word(32'(32'h204 + i * 4))) begin n_errors++; $display("FAIL lat_instr got %h exp %h", instruction, mem_word(32'(32'h204 + i * 4))); end
      n_checks++; if (imem_addr !== 32'(32'h208 + i * 4)) begin n_errors++; $display("FAIL lat_addr got %h exp %h", imem_addr, 32'(32'h208 + i * 4)); end
    end
    imem_ack = 1'b0; hz_write = 1'b1;
    tick();
    n_checks++; if (pc !== 32'h208) begin n_errors++; $display("FAIL stallwait_pc got %h exp %h", pc, 32'h208); end
    n_checks++; if (instruction !== mem_word(32'h208)) begin n_errors++; $display("FAIL stallwait_instr got %h exp %h", instruction, mem_word(32'h208)); end
    n_checks++; if (imem_addr !== 32'h20C) begin n_errors++; $display("FAIL stallwait_addr got %h exp %h", imem_addr, 32'h20C); end
    hz_write = 1'b0;
  endtask

  task automatic test_wrap();
    br_taken = 1'b1; br_target = 32'hFFFFFFFC; imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    n_checks++; if (imem_addr !== 32'hFFFFFFFC) begin n_errors++; $display("FAIL wrap_addr0 got %h exp %h", imem_addr, 32'hFFFFFFFC); end
    br_taken = 1'b0; imem_rdata = mem_word(32'hFFFFFFFC);
    tick();
    n_checks++; if (pc !== 32'hFFFFFFFC) begin n_errors++; $display("FAIL wrap_pc got %h exp %h", pc, 32'hFFFFFFFC); end
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL wrap_addr got %h exp %h", imem_addr, 32'h0); end
    imem_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL arst_pc got %h exp 0", pc); end
    n_checks++; if (instruction !== NOP) begin n_errors++; $display("FAIL arst_instr got %h exp %h", instruction, NOP); end
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL arst_req got %b exp 0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0;
    tick(); tick();
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL arst_hold_req got %b exp 0", imem_req); end
    n_checks++; if (instruction !== NOP) begin n_errors++; $display("FAIL arst_hold_instr got %h exp %h", instruction, NOP); end
    rst = 1'b0; imem_ack = 1'b0;
    tick();
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL arst_restart_addr got %h exp 0", imem_addr); end
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL arst_restart_req got %b exp 1", imem_req); end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    tick();
    n_checks++; if (instruction !== mem_word(32'h0)) begin n_errors++; $display("FAIL arst_first_instr got %h exp %h", instruction, mem_word(32'h0)); end
    n_checks++; if (imem_addr !== 32'h4) begin n_errors++; $display("FAIL arst_next_addr got %h exp %h", imem_addr, 32'h4); end
  endtask

  task automatic test_hold_redirect();
    imem_ack = 1'b1; hz_write = 1'b1; imem_rdata = mem_word(32'h4);
    tick();
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL hbr_hold_req got %b exp 0", imem_req); end
    imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h80;
    tick();
    n_checks++; if (imem_addr !== 32'h80) begin n_errors++; $display("FAIL hbr_addr got %h exp %h", imem_addr, 32'h80); end
    n_checks++; if (instruction !== NOP) begin n_errors++; $display("FAIL hbr_instr got %h exp %h", instruction, NOP); end
    n_checks++; if (pc !== 32'h80) begin n_errors++; $display("FAIL hbr_pc got %h exp %h", pc, 32'h80); end
    br_taken = 1'b0; hz_write = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(32'h80);
    tick();
    n_checks++; if (instruction !== mem_word(32'h80)) begin n_errors++; $display("FAIL hbr_tgt_instr got %h exp %h", instruction, mem_word(32'h80)); end
    n_checks++; if (imem_addr !== 32'h84) begin n_errors++; $display("FAIL hbr_tgt_addr got %h exp %h", imem_addr, 32'h84); end
    imem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_flush();
    test_latency();
    test_wrap();
    test_async_reset();
    test_hold_redirect();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
